forward_source: RTL and testbench
=================================

FORWARD_SOURCE -- requirements
Module: forward_source

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, the width of the stall counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-004 The block SHALL have port input_rd_addr, input, 5, the destination register of the instruction leaving EX this cycle.
REQ-005 The block SHALL have port input_alu_data, input, 32, the EX result of that instruction.
REQ-006 The block SHALL have port input_reg_write, input, 1, set when that instruction writes rd.
REQ-007 The block SHALL have port input_mem_read, input, 1, set when that instruction is a load.
REQ-008 The block SHALL have port input_mem_data, input, 32, the load data returned by memory for the instruction in the MEM stage, valid in the same cycle.
REQ-009 The block SHALL have port input_stop, input, 1, the load-use stall from the EX operand forwarder; the current EX slot is a bubble.
REQ-010 The block SHALL have port input_flush, input, 1, the branch/jump flush; the current EX slot is discarded.
REQ-011 The block SHALL have ports output_expro_addr (output, 5) and output_expro_data (output, 32), the EX/MEM forwarding source.
REQ-012 The block SHALL have ports output_mempro_addr (output, 5) and output_mempro_data (output, 32), the MEM/WB forwarding source.
REQ-013 The block SHALL have ports output_wb_en (output, 1), output_wb_addr (output, 5) and output_wb_data (output, 32), the register-file write port.
REQ-014 The block SHALL have port output_load_pending, output, 1, set when the EX/MEM entry is a valid load.
REQ-015 The block SHALL have port output_stall_count, output, CNT_W, the saturating count of cycles with input_stop set.

Function
REQ-016 The block SHALL hold an EX/MEM entry {rd, data, wen, is_load} and a MEM/WB entry {rd, data, wen}.
REQ-017 On each clock, with input_stop=0 and input_flush=0, EX/MEM SHALL capture {input_rd_addr, input_alu_data, input_reg_write, input_mem_read}.
REQ-018 When input_stop or input_flush is set, EX/MEM SHALL capture a bubble {0, 0, 0, 0}; when both are set, the flush takes priority and the result is the same bubble.
REQ-019 MEM/WB SHALL advance every cycle regardless of stop or flush, capturing rd and wen from EX/MEM; data SHALL be input_mem_data if EX/MEM is_load=1, else the EX/MEM data.
REQ-020 An EX/MEM or MEM/WB entry with rd=0 SHALL be stored with wen forced to 0.
REQ-021 output_expro_addr SHALL equal the EX/MEM rd when its wen=1, else 0.
REQ-022 output_expro_data SHALL equal 0 when EX/MEM is_load=1, else the EX/MEM data; the address is still published so the consumer raises input_stop.
REQ-023 output_mempro_addr/data SHALL equal the MEM/WB rd (0 when wen=0) and the MEM/WB data.
REQ-024 output_wb_en/addr/data SHALL mirror the MEM/WB entry combinationally, giving forwarding latency EX->expro of 1 cycle and EX->mempro/WB of 2 cycles.
REQ-025 output_load_pending SHALL equal EX/MEM is_load AND wen.
REQ-026 output_stall_count SHALL increment by 1 on each clock with input_stop=1 and hold at 2^CNT_W-1 with no wrap-around.
REQ-027 Each input_stop pulse SHALL produce exactly one bubble; because the load moves to MEM/WB on that cycle, the consumer's stop clears after one cycle.

Reset
REQ-028 While rst_n=0, asynchronously, both entries SHALL clear to bubbles and output_stall_count SHALL clear to 0, so every output reads 0.
REQ-029 Reset applied mid-operation SHALL discard any in-flight load; capture SHALL resume on the first rising clock edge after rst_n rises.

Verification
REQ-030 The bench SHALL cover: ALU op rd=3, data 0x1234, wen=1 -> next cycle expro=(3, 0x1234); cycle after that mempro=(3, 0x1234) and wb_en=1.
REQ-031 The bench SHALL cover: load rd=5, mem_read=1 -> expro=(5, 0), load_pending=1; then input_stop=1 and input_mem_data=0xCAFE -> next cycle expro_addr=0, mempro=(5, 0xCAFE), stall_count=1.
REQ-032 The bench SHALL cover: rd=0, wen=1, data 0xFFFF -> expro_addr=0, and two cycles later wb_en=0.
REQ-033 The bench SHALL cover: input_flush=1 together with a valid ALU op -> expro_addr=0 next cycle while the prior MEM/WB entry still reaches WB.
REQ-034 The bench SHALL cover: CNT_W=2 with stop held 5 cycles -> stall_count reads 1, 2, 3, 3, 3.
REQ-035 The bench SHALL cover: rst_n dropped between clock edges while a load is in EX/MEM -> all outputs read 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/forward_source.sv
// EX/MEM and MEM/WB forwarding sources plus WB write port. EX->expro is 1 cycle, EX->mempro/WB is 2 cycles.
// Stop or flush turn the EX slot into a bubble; MEM/WB always advances, and stall cycles are counted with saturation.
module forward_source #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       input_rd_addr,
   input  logic [31:0]      input_alu_data,
   input  logic             input_reg_write,
   input  logic             input_mem_read,
   input  logic [31:0]      input_mem_data,
   input  logic             input_stop,
   input  logic             input_flush,
   output logic [4:0]       output_expro_addr,
   output logic [31:0]      output_expro_data,
   output logic [4:0]       output_mempro_addr,
   output logic [31:0]      output_mempro_data,
   output logic             output_wb_en,
   output logic [4:0]       output_wb_addr,
   output logic [31:0]      output_wb_data,
   output logic             output_load_pending,
   output logic [CNT_W-1:0] output_stall_count
);

   logic [4:0]       em_rd;
   logic [31:0]      em_data;
   logic             em_wen;
   logic             em_load;
   logic [4:0]       mw_rd;
   logic [31:0]      mw_data;
   logic             mw_wen;
   logic [CNT_W-1:0] stall_cnt;
   logic             bubble;

   assign bubble = input_stop | input_flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         em_rd     <= '0;
         em_data   <= '0;
         em_wen    <= 1'b0;
         em_load   <= 1'b0;
         mw_rd     <= '0;
         mw_data   <= '0;
         mw_wen    <= 1'b0;
         stall_cnt <= '0;
      end else begin
         if (bubble) begin
            em_rd   <= '0;
            em_data <= '0;
            em_wen  <= 1'b0;
            em_load <= 1'b0;
         end else begin
            em_rd   <= input_rd_addr;
            em_data <= input_alu_data;
            em_wen  <= input_reg_write & (input_rd_addr != 5'd0);
            em_load <= input_mem_read;
         end
         // MEM/WB never stalls: the load drains on the stop cycle, so the consumer's stop lasts one cycle.
         mw_rd   <= em_rd;
         mw_data <= em_load ? input_mem_data : em_data;
         mw_wen  <= em_wen & (em_rd != 5'd0);
         if (input_stop && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   // A load's address is published with zero data so the consumer detects the hazard and stops.
   assign output_expro_addr   = em_wen ? em_rd : 5'd0;
   assign output_expro_data   = em_load ? 32'd0 : em_data;
   assign output_mempro_addr  = mw_wen ? mw_rd : 5'd0;
   assign output_mempro_data  = mw_data;
   assign output_wb_en        = mw_wen;
   assign output_wb_addr      = mw_rd;
   assign output_wb_data      = mw_data;
   assign output_load_pending = em_load & em_wen;
   assign output_stall_count  = stall_cnt;

endmodule

// File: tb/tb_forward_source.sv
// Scoreboard bench for forward_source: default-width and CNT_W=2 instances share one stimulus stream.
module tb_forward_source;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rd_addr;
   logic [31:0] alu_data;
   logic        reg_write;
   logic        mem_read;
   logic [31:0] mem_data;
   logic        stop;
   logic        flush;

   logic [4:0]  expro_addr, mempro_addr, wb_addr;
   logic [31:0] expro_data, mempro_data, wb_data;
   logic        wb_en, load_pending;
   logic [15:0] stall_count;

   logic [4:0]  d2_expro_addr, d2_mempro_addr, d2_wb_addr;
   logic [31:0] d2_expro_data, d2_mempro_data, d2_wb_data;
   logic        d2_wb_en, d2_load_pending;
   logic [1:0]  d2_stall_count;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   forward_source dut (
      .clk(clk), .rst_n(rst_n),
      .input_rd_addr(rd_addr), .input_alu_data(alu_data), .input_reg_write(reg_write),
      .input_mem_read(mem_read), .input_mem_data(mem_data), .input_stop(stop), .input_flush(flush),
      .output_expro_addr(expro_addr), .output_expro_data(expro_data),
      .output_mempro_addr(mempro_addr), .output_mempro_data(mempro_data),
      .output_wb_en(wb_en), .output_wb_addr(wb_addr), .output_wb_data(wb_data),
      .output_load_pending(load_pending), .output_stall_count(stall_count)
   );

   forward_source #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .input_rd_addr(rd_addr), .input_alu_data(alu_data), .input_reg_write(reg_write),
      .input_mem_read(mem_read), .input_mem_data(mem_data), .input_stop(stop), .input_flush(flush),
      .output_expro_addr(d2_expro_addr), .output_expro_data(d2_expro_data),
      .output_mempro_addr(d2_mempro_addr), .output_mempro_data(d2_mempro_data),
      .output_wb_en(d2_wb_en), .output_wb_addr(d2_wb_addr), .output_wb_data(d2_wb_data),
      .output_load_pending(d2_load_pending), .output_stall_count(d2_stall_count)
   );

   typedef struct {
      logic [4:0]  ea;
      logic [31:0] ed;
      logic        lp;
      logic [4:0]  ma;
      logic [31:0] md;
      logic        we;
      logic [4:0]  wa;
      logic [15:0] c16;
      logic [1:0]  c2;
   } exp_t;

   exp_t exp_q[$];

   // Pipeline contents expected after each clock edge.
   logic [4:0]  m_ex_rd, m_mw_rd;
   logic [31:0] m_ex_data, m_mw_data;
   logic        m_ex_wen, m_ex_ld, m_mw_wen;
   logic [15:0] m_c16;
   logic [1:0]  m_c2;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic model_clear();
      m_ex_rd = '0; m_ex_data = '0; m_ex_wen = 1'b0; m_ex_ld = 1'b0;
      m_mw_rd = '0; m_mw_data = '0; m_mw_wen = 1'b0;
      m_c16 = '0; m_c2 = '0;
   endtask

   task automatic drive_idle();
      rd_addr = '0; alu_data = '0; reg_write = 1'b0; mem_read = 1'b0;
      mem_data = '0; stop = 1'b0; flush = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".expro_addr"}, 32'(expro_addr), 32'd0);
      chk({tag, ".expro_data"}, expro_data, 32'd0);
      chk({tag, ".mempro_addr"}, 32'(mempro_addr), 32'd0);
      chk({tag, ".mempro_data"}, mempro_data, 32'd0);
      chk({tag, ".wb"}, {wb_en, wb_addr, wb_data[25:0]}, 32'd0);
      chk({tag, ".wb_data"}, wb_data, 32'd0);
      chk({tag, ".load_pending"}, 32'(load_pending), 32'd0);
      chk({tag, ".stall16"}, 32'(stall_count), 32'd0);
      chk({tag, ".stall2"}, 32'(d2_stall_count), 32'd0);
   endtask

   task automatic step(input logic [4:0] rd, input logic [31:0] alu, input logic we,
                       input logic mr, input logic [31:0] md, input logic st, input logic fl);
      exp_t e;
      @(negedge clk);
      rd_addr = rd; alu_data = alu; reg_write = we; mem_read = mr;
      mem_data = md; stop = st; flush = fl;
      m_mw_rd   = m_ex_rd;
      m_mw_data = m_ex_ld ? md : m_ex_data;
      m_mw_wen  = m_ex_wen;
      if (st || fl) begin
         m_ex_rd = '0; m_ex_data = '0; m_ex_wen = 1'b0; m_ex_ld = 1'b0;
      end else begin
         m_ex_rd = rd; m_ex_data = alu; m_ex_wen = we && (rd != 5'd0); m_ex_ld = mr;
      end
      if (st) begin
         if (m_c16 != 16'hFFFF) m_c16++;
         if (m_c2 != 2'd3) m_c2++;
      end
      e.ea  = m_ex_wen ? m_ex_rd : 5'd0;
      e.ed  = m_ex_ld ? 32'd0 : m_ex_data;
      e.lp  = m_ex_ld && m_ex_wen;
      e.ma  = m_mw_wen ? m_mw_rd : 5'd0;
      e.md  = m_mw_data;
      e.we  = m_mw_wen;
      e.wa  = m_mw_rd;
      e.c16 = m_c16;
      e.c2  = m_c2;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("sb.expro_addr", 32'(expro_addr), 32'(e.ea));
      chk("sb.expro_data", expro_data, e.ed);
      chk("sb.load_pending", 32'(load_pending), 32'(e.lp));
      chk("sb.mempro_addr", 32'(mempro_addr), 32'(e.ma));
      chk("sb.mempro_data", mempro_data, e.md);
      chk("sb.wb_en", 32'(wb_en), 32'(e.we));
      chk("sb.wb_addr", 32'(wb_addr), 32'(e.wa));
      chk("sb.wb_data", wb_data, e.md);
      chk("sb.stall16", 32'(stall_count), 32'(e.c16));
      chk("sb.stall2", 32'(d2_stall_count), 32'(e.c2));
      chk("sb2.expro", {d2_expro_addr, d2_expro_data[26:0]}, {e.ea, e.ed[26:0]});
      chk("sb2.mempro", {d2_mempro_addr, d2_mempro_data[26:0]}, {e.ma, e.md[26:0]});
      chk("sb2.wb", {d2_wb_en, d2_wb_addr, d2_load_pending, d2_wb_data[24:0]},
          {e.we, e.wa, e.lp, e.md[24:0]});
   endtask

   initial begin
      logic [1:0] sat_seq [5];
      sat_seq[0] = 2'd1; sat_seq[1] = 2'd2; sat_seq[2] = 2'd3; sat_seq[3] = 2'd3; sat_seq[4] = 2'd3;

      rst_n = 1'b0;
      drive_idle();
      model_clear();
      #1 check_zero("rst_init");
      repeat (2) @(posedge clk);
      #1 check_zero("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;

      // ALU result forwarded at 1 cycle, written back at 2.
      step(5'd3, 32'h1234, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("alu.expro_addr", 32'(expro_addr), 32'd3);
      chk("alu.expro_data", expro_data, 32'h1234);
      // Load enters EX/MEM while the ALU op reaches MEM/WB.
      step(5'd5, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
      chk("alu.mempro_addr", 32'(mempro_addr), 32'd3);
      chk("alu.mempro_data", mempro_data, 32'h1234);
      chk("alu.wb_en", 32'(wb_en), 32'd1);
      chk("ld.expro_addr", 32'(expro_addr), 32'd5);
      chk("ld.expro_data", expro_data, 32'd0);
      chk("ld.load_pending", 32'(load_pending), 32'd1);
      // Load-use stop: one bubble, load data lands in MEM/WB.
      step(5'd7, 32'h77, 1'b1, 1'b0, 32'hCAFE, 1'b1, 1'b0);
      chk("stop.expro_addr", 32'(expro_addr), 32'd0);
      chk("stop.mempro_addr", 32'(mempro_addr), 32'd5);
      chk("stop.mempro_data", mempro_data, 32'hCAFE);
      chk("stop.stall16", 32'(stall_count), 32'd1);
      // Writes to x0 are never forwarded or written back.
      step(5'd0, 32'hFFFF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("x0.expro_addr", 32'(expro_addr), 32'd0);
      step(5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("x0.wb_en", 32'(wb_en), 32'd0);
      // Flush discards the EX op but the older op still writes back.
      step(5'd9, 32'hAAAA, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      step(5'd10, 32'hBBBB, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("flush.expro_addr", 32'(expro_addr), 32'd0);
      chk("flush.wb_en", 32'(wb_en), 32'd1);
      chk("flush.wb_addr", 32'(wb_addr), 32'd9);
      chk("flush.wb_data", wb_data, 32'hAAAA);
      step(5'd11, 32'hCCCC, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      chk("stopflush.expro_addr", 32'(expro_addr), 32'd0);

      // Asynchronous reset while a load sits in EX/MEM.
      step(5'd6, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      drive_idle();
      #1 check_zero("rst_async");
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;

      // Saturating stall counter on the narrow instance.
      for (int i = 0; i < 5; i++) begin
         step(5'd4, 32'h44, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
         chk("sat.stall2", 32'(d2_stall_count), 32'(sat_seq[i]));
         chk("sat.stall16", 32'(stall_count), 32'(i + 1));
      end

      for (int i = 0; i < 300; i++) begin
         step(5'($urandom_range(0, 31)), $urandom, 1'($urandom), ($urandom_range(0, 3) == 0),
              $urandom, ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
